// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the FPGA configuration loader: FSM state encoding,
// CRC-16-CCITT constants and chain sizing helpers.
// Build option: CFG_CRC_EN adds the CHECK state and a trailing CRC word.
package fpga_cfg_pkg;

`ifdef CFG_CRC_EN
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StShift = 3'd2,
    StSet   = 3'd3,
    StDone  = 3'd4,
    StCheck = 3'd5
  } cfg_state_e;
`else
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StShift = 3'd2,
    StSet   = 3'd3,
    StDone  = 3'd4
  } cfg_state_e;
`endif

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // Shift cycles needed to fill one column chain.
  function automatic int unsigned chain_len(input int unsigned rows, input int unsigned bits);
    return rows * bits;
  endfunction

  // Data words needed to cover a chain when each word yields bpw shift cycles.
  function automatic int unsigned nwords(input int unsigned len, input int unsigned bpw);
    return (len + bpw - 1) / bpw;
  endfunction

endpackage

// File: rtl/fpga_cfg_loader_if.sv
// Valid/ready config word stream between the host/IO side and the loader.
interface fpga_cfg_loader_if #(
  parameter int unsigned WORD_W = 32
);
  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/fpga_cfg_crc16.sv
// CRC-16-CCITT accumulator that absorbs NUM_COLS bits per enabled cycle,
// bit 0 first, matching the column order of one shift cycle.
module fpga_cfg_crc16
  import fpga_cfg_pkg::*;
#(
  parameter int unsigned NUM_COLS = 2
) (
  input  logic                i_cclk,
  input  logic                i_rst,
  input  logic                i_clear,
  input  logic                i_en,
  input  logic [NUM_COLS-1:0] i_bits,
  output logic [15:0]         o_crc
);

  logic [15:0] r_crc;
  logic [15:0] w_crc_next;

  // Fold the cycle's bits into the running CRC one at a time.
  always_comb begin
    w_crc_next = r_crc;
    for (int i = 0; i < int'(NUM_COLS); i++) begin
      if (w_crc_next[15] ^ i_bits[i]) begin
        w_crc_next = {w_crc_next[14:0], 1'b0} ^ CRC16_POLY;
      end else begin
        w_crc_next = {w_crc_next[14:0], 1'b0};
      end
    end
  end

  // CRC register: seeded at load start, updated on shift cycles.
  always_ff @(posedge i_cclk) begin
    if (i_rst || i_clear) begin
      r_crc <= CRC16_INIT;
    end else if (i_en) begin
      r_crc <= w_crc_next;
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/fpga_cfg_loader.sv
// Bitstream loader: takes config words from a valid/ready stream, shifts them
// into NUM_COLS parallel column chains, then pulses set_hard to commit.
// Build option: CFG_CRC_EN appends a CRC word and a CHECK state; a mismatch
// skips the commit and raises crc_err.
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter int unsigned NUM_COLS      = 2,
  parameter int unsigned NUM_ROWS      = 2,
  parameter int unsigned TILE_CFG_BITS = 1600,
  parameter int unsigned WORD_W        = 32
) (
  input  logic                i_cclk,
  input  logic                i_rst,
  input  logic                i_start,
  fpga_cfg_loader_if.slave    io_cfg,
  output logic [NUM_COLS-1:0] o_shift_enable,
  output logic [NUM_COLS-1:0] o_shift_in_hard,
  output logic [NUM_COLS-1:0] o_set_hard,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_crc_err
);

  localparam int unsigned CHAIN_LEN = chain_len(NUM_ROWS, TILE_CFG_BITS);
  localparam int unsigned BPW       = WORD_W / NUM_COLS;
  localparam int unsigned NWORDS    = nwords(CHAIN_LEN, BPW);
  localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam int unsigned BEAT_W    = (BPW > 1) ? $clog2(BPW) : 1;

  if (WORD_W % NUM_COLS != 0) begin : g_bad_word_w
    $error("WORD_W must be a multiple of NUM_COLS");
  end
  if (NWORDS * BPW < CHAIN_LEN) begin : g_bad_nwords
    $error("word count does not cover the chain");
  end

  cfg_state_e          r_state;
  cfg_state_e          w_state_d;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [BEAT_W-1:0]   r_beat;
  logic [WORD_W-1:0]   r_buf;
  logic [NUM_COLS-1:0] r_shift_en;
  logic [NUM_COLS-1:0] r_shift_in;
  logic [NUM_COLS-1:0] r_set_hard;
  logic                r_in_ready;
  logic                r_busy;
  logic                r_done;

  logic w_accept;
  logic w_start;
  logic w_last_bit;
  logic w_last_beat;

  // in_ready is a registered copy of "state is LOAD", so it doubles as the state test.
  assign w_accept    = r_in_ready && io_cfg.in_valid;
  assign w_start     = (r_state == StIdle) && i_start;
  assign w_last_bit  = (r_bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign w_last_beat = (r_beat == BEAT_W'(BPW - 1));

`ifdef CFG_CRC_EN
  localparam int unsigned CRC_W = (WORD_W < 16) ? WORD_W : 16;

  logic [15:0] w_crc;
  logic [15:0] r_crc_exp;
  logic        r_crc_err;
  logic        w_crc_phase;
  logic        w_crc_ok;

  // All data shifted means the next accepted word carries the expected CRC.
  assign w_crc_phase = (r_bit_cnt == CNT_W'(CHAIN_LEN));
  assign w_crc_ok    = (w_crc == r_crc_exp);

  fpga_cfg_crc16 #(
    .NUM_COLS(NUM_COLS)
  ) u_crc (
    .i_cclk (i_cclk),
    .i_rst  (i_rst),
    .i_clear(w_start),
    .i_en   (r_state == StShift),
    .i_bits (r_shift_in),
    .o_crc  (w_crc)
  );

  // Expected CRC capture and sticky error flag, cleared by the next start.
  always_ff @(posedge i_cclk) begin
    if (i_rst) begin
      r_crc_exp <= '0;
      r_crc_err <= 1'b0;
    end else begin
      if (w_accept && w_crc_phase) begin
        r_crc_exp <= 16'(io_cfg.in_data[CRC_W-1:0]);
      end
      if (w_start) begin
        r_crc_err <= 1'b0;
      end else if ((r_state == StCheck) && !w_crc_ok) begin
        r_crc_err <= 1'b1;
      end
    end
  end

  assign o_crc_err = r_crc_err;
`else
  assign o_crc_err = 1'b0;
`endif

  // Next-state logic for the load sequence.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (i_start) w_state_d = StLoad;
      end
      StLoad: begin
        if (w_accept) begin
`ifdef CFG_CRC_EN
          w_state_d = w_crc_phase ? StCheck : StShift;
`else
          w_state_d = StShift;
`endif
        end
      end
      StShift: begin
        if (w_last_bit) begin
`ifdef CFG_CRC_EN
          w_state_d = StLoad;
`else
          w_state_d = StSet;
`endif
        end else if (w_last_beat) begin
          w_state_d = StLoad;
        end
      end
`ifdef CFG_CRC_EN
      StCheck: begin
        w_state_d = w_crc_ok ? StSet : StDone;
      end
`endif
      StSet:   w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge i_cclk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Bit/beat counters and word buffer; the buffer holds bits not yet presented.
  always_ff @(posedge i_cclk) begin
    if (i_rst) begin
      r_bit_cnt <= '0;
      r_beat    <= '0;
      r_buf     <= '0;
    end else begin
      if (w_start) begin
        r_bit_cnt <= '0;
        r_beat    <= '0;
      end
      if (w_accept) begin
        r_buf  <= io_cfg.in_data >> NUM_COLS;
        r_beat <= '0;
      end
      if (r_state == StShift) begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        r_beat    <= r_beat + BEAT_W'(1);
        r_buf     <= r_buf >> NUM_COLS;
      end
    end
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge i_cclk) begin
    if (i_rst) begin
      r_shift_en <= '0;
      r_shift_in <= '0;
      r_set_hard <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_shift_en <= {NUM_COLS{w_state_d == StShift}};
      r_set_hard <= {NUM_COLS{w_state_d == StSet}};
      r_in_ready <= (w_state_d == StLoad);
      r_busy     <= (w_state_d != StIdle);
      r_done     <= (w_state_d == StDone);
      // First beat of a word comes straight from the bus, later beats from the buffer.
      if (w_state_d == StShift) begin
        r_shift_in <= (r_state == StLoad) ? io_cfg.in_data[NUM_COLS-1:0]
                                          : r_buf[NUM_COLS-1:0];
      end else begin
        r_shift_in <= '0;
      end
    end
  end

  assign io_cfg.in_ready = r_in_ready;
  assign o_shift_enable  = r_shift_en;
  assign o_shift_in_hard = r_shift_in;
  assign o_set_hard      = r_set_hard;
  assign o_busy          = r_busy;
  assign o_done          = r_done;

endmodule
